// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg
// Shared constants and helpers for the pipelined adder/subtractor.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and pipeline depth
//   faResult_t                     : result of a single full-adder cell
//   chunkWidth()                   : bits handled by each pipeline stage
//   widthDivisible()               : legality check on the WIDTH/STAGES pair
//   fullAdder()                    : one-bit full-adder cell
package adder_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic carry;
    logic sum;
  } faResult_t;

  function automatic int chunkWidth(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit widthDivisible(input int width, input int stages);
    return (stages > 0) && ((width % stages) == 0);
  endfunction

  function automatic faResult_t fullAdder(input logic a, input logic b, input logic cIn);
    faResult_t r;
    r.sum   = a ^ b ^ cIn;
    r.carry = (a & b) | (cIn & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk
// Combinational ripple-carry adder for one pipeline chunk, built from
// full-adder cells.
//   a_i, b_i : chunk operands (b_i already conditioned for subtract)
//   c_i      : carry into bit 0
//   sum_o    : chunk sum
//   cout_o   : carry out of the chunk MSB
//   cmsb_o   : carry into the chunk MSB, used for signed overflow
module adder_chunk
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  // Ripple the carry LSB to MSB through one full-adder cell per bit. The
  // carry entering the top bit is captured on the way so the final stage
  // can form the overflow flag without a second adder.
  always_comb begin : rippleProc
    logic      carry;
    faResult_t fa;
    carry  = c_i;
    fa     = '0;
    sum_o  = '0;
    cmsb_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        cmsb_o = carry;
      end
      fa       = fullAdder(a_i[i], b_i[i], carry);
      sum_o[i] = fa.sum;
      carry    = fa.carry;
    end
    cout_o = carry;
  end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe
// Pipelined ripple-carry adder/subtractor with valid/ready handshake. The
// WIDTH-bit operation is split into STAGES chunks; stage k adds chunk k using
// the carry registered by stage k-1, so no stage ripples more than CHUNK bits.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid, o_ready    : operand handshake
//   i_a, i_b            : operands
//   i_c_in              : carry-in (add) / borrow-in (subtract)
//   i_sub               : 0 = A + B + c_in, 1 = A - B - borrow_in
//   o_valid, i_ready    : result handshake
//   o_sum, o_cout, o_ovf: result, carry out of MSB (1 = no borrow when
//                         subtracting), signed overflow
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CHUNK = chunkWidth(WIDTH, STAGES);

  if (!widthDivisible(WIDTH, STAGES)) begin : gBadParams
    $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             en;
  logic             accept;
  logic             cinCond;
  logic [WIDTH-1:0] bCond;

  // Per-stage registers. Operand copies travel with the partial sum so each
  // stage finds its own chunk of A and B' still waiting for it.
  logic             validQ [STAGES];
  logic             validD [STAGES];
  logic [WIDTH-1:0] aQ     [STAGES];
  logic [WIDTH-1:0] aD     [STAGES];
  logic [WIDTH-1:0] bQ     [STAGES];
  logic [WIDTH-1:0] bD     [STAGES];
  logic [WIDTH-1:0] sumQ   [STAGES];
  logic [WIDTH-1:0] sumD   [STAGES];
  logic             carryQ [STAGES];
  logic             carryD [STAGES];
  logic             ovfQ   [STAGES];
  logic             ovfD   [STAGES];

  logic [CHUNK-1:0] chunkA    [STAGES];
  logic [CHUNK-1:0] chunkB    [STAGES];
  logic             chunkCin  [STAGES];
  logic [CHUNK-1:0] chunkSum  [STAGES];
  logic             chunkCout [STAGES];
  logic             chunkCmsb [STAGES];

  // The whole pipe advances together: it may move whenever the output slot
  // is empty or being drained this cycle. Subtraction is A + ~B + ~borrow.
  assign en      = !o_valid || i_ready;
  assign o_ready = en && !i_rst;
  assign accept  = i_valid && o_ready;
  assign bCond   = i_sub ? ~i_b : i_b;
  assign cinCond = i_c_in ^ i_sub;

  // Select what each chunk adder sees: stage 0 works straight off the
  // conditioned inputs, later stages off the previous stage's registers.
  always_comb begin
    chunkA[0]   = i_a[CHUNK-1:0];
    chunkB[0]   = bCond[CHUNK-1:0];
    chunkCin[0] = cinCond;
    for (int k = 1; k < STAGES; k++) begin
      chunkA[k]   = aQ[k-1][k*CHUNK +: CHUNK];
      chunkB[k]   = bQ[k-1][k*CHUNK +: CHUNK];
      chunkCin[k] = carryQ[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gChunk
    adder_chunk #(
      .WIDTH(CHUNK)
    ) uChunk (
      .a_i   (chunkA[k]),
      .b_i   (chunkB[k]),
      .c_i   (chunkCin[k]),
      .sum_o (chunkSum[k]),
      .cout_o(chunkCout[k]),
      .cmsb_o(chunkCmsb[k])
    );
  end

  // Next-state for every stage: forward operands, valid and the lower sum
  // chunks already finished, then drop this stage's chunk sum into place.
  always_comb begin
    aD[0]               = i_a;
    bD[0]               = bCond;
    validD[0]           = accept;
    sumD[0]             = '0;
    sumD[0][CHUNK-1:0]  = chunkSum[0];
    for (int k = 1; k < STAGES; k++) begin
      aD[k]                      = aQ[k-1];
      bD[k]                      = bQ[k-1];
      validD[k]                  = validQ[k-1];
      sumD[k]                    = sumQ[k-1];
      sumD[k][k*CHUNK +: CHUNK]  = chunkSum[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      carryD[k] = chunkCout[k];
      ovfD[k]   = chunkCmsb[k] ^ chunkCout[k];
    end
  end

  // Stage registers. A stall freezes everything; data registers only load
  // when a valid item is arriving so idle stages do not toggle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        validQ[k] <= 1'b0;
        aQ[k]     <= '0;
        bQ[k]     <= '0;
        sumQ[k]   <= '0;
        carryQ[k] <= 1'b0;
        ovfQ[k]   <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        validQ[k] <= validD[k];
        if (validD[k]) begin
          aQ[k]     <= aD[k];
          bQ[k]     <= bD[k];
          sumQ[k]   <= sumD[k];
          carryQ[k] <= carryD[k];
          ovfQ[k]   <= ovfD[k];
        end
      end
    end
  end

  assign o_valid = validQ[STAGES-1];
  assign o_sum   = sumQ[STAGES-1];
  assign o_cout  = carryQ[STAGES-1];
  assign o_ovf   = ovfQ[STAGES-1];

endmodule
